// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: header (N words), 4*N LE payload bytes, XOR checksum -> IMEM writes.
// Latency: a word is written the cycle after its 4th byte; flags update on the consuming edge.
// Backpressure: in_ready is high in every load state (1 byte/cycle), low in IDLE/DONE/ERROR.
module imem_boot_loader #(
    parameter int IMEM_WORDS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVERSIZE = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;

    state_t            state_q,      state_d;
    logic [7:0]        hdr_lo_q,     hdr_lo_d;
    logic [ADDR_W:0]   n_q,          n_d;
    logic [1:0]        idx_q,        idx_d;
    logic [23:0]       buf_q,        buf_d;
    logic [7:0]        csum_q,       csum_d;
    logic              in_ready_q,   in_ready_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [31:0]       wdata_q,      wdata_d;
    logic              hold_q,       hold_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              error_q,      error_d;
    logic [1:0]        err_code_q,   err_code_d;
    logic [ADDR_W:0]   wc_q,         wc_d;

    logic              xfer;
    logic [15:0]       n_full;
    logic [ADDR_W:0]   wc_inc;

    assign xfer   = in_valid & in_ready_q;
    assign n_full = {in_data, hdr_lo_q};
    assign wc_inc = wc_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        hdr_lo_d   = hdr_lo_q;
        n_d        = n_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        wc_d       = wc_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_HDR_LO;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    wc_d       = '0;
                    idx_d      = 2'd0;
                    csum_d     = 8'h00;
                    hold_d     = 1'b1;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    hdr_lo_d = in_data;
                    state_d  = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    if (n_full > 16'(IMEM_WORDS)) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_OVERSIZE;
                    end else if (n_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        n_d     = n_full[ADDR_W:0];
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    csum_d = csum_q ^ in_data;
                    idx_d  = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: buf_d[7:0]   = in_data;
                        2'd1: buf_d[15:8]  = in_data;
                        2'd2: buf_d[23:16] = in_data;
                        default: begin
                            // Fourth byte completes the word; address is the pre-increment count.
                            we_d    = 1'b1;
                            addr_d  = wc_q[ADDR_W-1:0];
                            wdata_d = {in_data, buf_q};
                            wc_d    = wc_inc;
                            if (wc_inc == n_q) begin
                                state_d = S_CHECK;
                            end
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                     (state_d == S_PAYLOAD) || (state_d == S_CHECK);
        busy_d     = in_ready_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hdr_lo_q   <= 8'h00;
            n_q        <= '0;
            idx_q      <= 2'd0;
            buf_q      <= 24'h0;
            csum_q     <= 8'h00;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            wc_q       <= '0;
        end else begin
            state_q    <= state_d;
            hdr_lo_q   <= hdr_lo_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            csum_q     <= csum_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            wc_q       <= wc_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_hold  = hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: reset state, good/bad loads, oversize and empty images, mid-load reset.
module tb_imem_boot_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];

    imem_boot_loader #(.IMEM_WORDS(64), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader accepts it (bounded wait).
    task automatic send(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("rdy_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Two-word program: header 02 00, words 0x00000013 and 0x00100093; first nb bytes only.
    task automatic send_prog(input int nb, input bit gap);
        logic [7:0] s [10];
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < nb; i++) send(s[i], gap);
    endtask

    task automatic check_two_words(input string tag, input int base);
        chk({tag, "_nwr"}, log_addr.size() - base, 32'd2);
        if (log_addr.size() >= base + 2) begin
            chk({tag, "_a0"}, {26'b0, log_addr[base]},     32'd0);
            chk({tag, "_d0"}, log_data[base],              32'h0000_0013);
            chk({tag, "_a1"}, {26'b0, log_addr[base + 1]}, 32'd1);
            chk({tag, "_d1"}, log_data[base + 1],          32'h0010_0093);
        end
    endtask

    initial begin
        int base;

        // 1: reset state, then idle with no start
        cycles(3);
        chk("rst_hold",  {31'b0, core_hold}, 32'd1);
        chk("rst_rdy",   {31'b0, in_ready},  32'd0);
        chk("rst_we",    {31'b0, imem_we},   32'd0);
        chk("rst_busy",  {31'b0, busy},      32'd0);
        chk("rst_flags", {29'b0, done, error, 1'b0} | {30'b0, err_code}, 32'd0);
        chk("rst_wc",    {25'b0, word_count}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        cycles(8);
        in_valid = 1'b0;
        chk("idle_hold", {31'b0, core_hold}, 32'd1);
        chk("idle_rdy",  {31'b0, in_ready},  32'd0);
        chk("idle_done", {31'b0, done},      32'd0);
        chk("idle_nwr",  log_addr.size(),    32'd0);

        // 2: good two-word load, checksum 0x13^0x93^0x10 = 0x90
        base = log_addr.size();
        pulse_start();
        chk("c2_busy", {31'b0, busy},     32'd1);
        chk("c2_rdy",  {31'b0, in_ready}, 32'd1);
        send_prog(10, 1'b0);
        send(8'h90, 1'b0);
        in_valid = 1'b0;
        cycles(1);
        check_two_words("c2", base);
        chk("c2_done", {31'b0, done},      32'd1);
        chk("c2_err",  {31'b0, error},     32'd0);
        chk("c2_hold", {31'b0, core_hold}, 32'd0);
        chk("c2_wc",   {25'b0, word_count}, 32'd2);
        chk("c2_idle", {30'b0, busy, in_ready}, 32'd0);

        // 3: same image, bad checksum
        base = log_addr.size();
        pulse_start();
        chk("c3_hold_at_start", {31'b0, core_hold}, 32'd1);
        send_prog(10, 1'b0);
        send(8'h81, 1'b0);
        in_valid = 1'b0;
        cycles(1);
        check_two_words("c3", base);
        chk("c3_err",  {31'b0, error},     32'd1);
        chk("c3_code", {30'b0, err_code},  32'd2);
        chk("c3_hold", {31'b0, core_hold}, 32'd1);
        chk("c3_done", {31'b0, done},      32'd0);

        // 4: oversize header, 65 words
        base = log_addr.size();
        pulse_start();
        send(8'h41, 1'b0);
        send(8'h00, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h13;
        cycles(4);
        in_valid = 1'b0;
        chk("c4_err",  {31'b0, error},    32'd1);
        chk("c4_code", {30'b0, err_code}, 32'd1);
        chk("c4_rdy",  {31'b0, in_ready}, 32'd0);
        chk("c4_nwr",  log_addr.size() - base, 32'd0);

        // 5: empty image; byte presented with start must not be consumed
        base = log_addr.size();
        in_valid = 1'b1;
        in_data  = 8'h00;
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        in_valid = 1'b0;
        cycles(1);
        chk("c5_done", {31'b0, done},       32'd1);
        chk("c5_wc",   {25'b0, word_count}, 32'd0);
        chk("c5_nwr",  log_addr.size() - base, 32'd0);
        chk("c5_hold", {31'b0, core_hold},  32'd0);

        // 5b: good load with in_valid gaps every other cycle
        base = log_addr.size();
        pulse_start();
        send_prog(10, 1'b1);
        send(8'h90, 1'b1);
        check_two_words("c5b", base);
        chk("c5b_done", {31'b0, done}, 32'd1);

        // 6: reset after 6 payload bytes, then a clean reload
        base = log_addr.size();
        pulse_start();
        send_prog(8, 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("c6_nwr",   log_addr.size() - base, 32'd1);
        if (log_addr.size() > base) chk("c6_d0", log_data[base], 32'h0000_0013);
        chk("c6_hold",  {31'b0, core_hold}, 32'd1);
        chk("c6_flags", {28'b0, busy, done, error, in_ready}, 32'd0);
        chk("c6_wc",    {25'b0, word_count}, 32'd0);
        cycles(2);
        reset = 1'b1;
        cycles(3);
        chk("c6_nwr_after", log_addr.size() - base, 32'd1);
        base = log_addr.size();
        pulse_start();
        send_prog(10, 1'b0);
        send(8'h90, 1'b0);
        in_valid = 1'b0;
        cycles(1);
        check_two_words("c6r", base);
        chk("c6r_done", {31'b0, done}, 32'd1);
        chk("c6r_wc",   {25'b0, word_count}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
